// File: rtl/data_mem_controller_if.sv
// Word-wide data memory bus between the MEM-stage controller and memory.
//
// Handshake: the controller (master) raises DataMem_Read or any bit of
// DataMem_Write together with DataMem_Address/DataMem_Out and keeps all of
// them stable until the memory (slave) answers with DataMem_Ready=1 for one
// cycle. That cycle completes the access: read data on DataMem_In is valid
// only in that cycle. The strobes drop on the following edge. Ready seen
// while no strobe is raised carries no meaning and is ignored.
interface data_mem_controller_if #(
  parameter int BUS_ADDR_W = 30
);
  logic                  DataMem_Read;
  logic [3:0]            DataMem_Write;
  logic [BUS_ADDR_W-1:0] DataMem_Address;
  logic [31:0]           DataMem_Out;
  logic [31:0]           DataMem_In;
  logic                  DataMem_Ready;

  modport master (
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
    input  DataMem_In, DataMem_Ready
  );

  modport slave (
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
    output DataMem_In, DataMem_Ready
  );
endinterface

// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: big-endian lane steering, load
// extension, LL/SC reservation and a stall request for the hazard unit.
module data_mem_controller #(
  parameter int BUS_ADDR_W = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MEM_MemRead,
  input  logic                  MEM_MemWrite,
  input  logic [1:0]            MEM_Size,
  input  logic                  MEM_SignExtend,
  input  logic                  MEM_LLSC,
  input  logic [31:0]           MEM_Address,
  input  logic [31:0]           MEM_WriteData,
  input  logic                  MEM_PipeStall,
  input  logic                  LLSC_Clear,
  output logic                  MEM_Stall_Controller,
  output logic [31:0]           MEM_ReadData,
  output logic                  MEM_AddrError,
  output logic [1:0]            debug_state,
  data_mem_controller_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_next;

  logic                  is_access, addr_error, sc_fail, req, complete;
  logic                  resv_valid, resv_clear, resv_set;
  logic [BUS_ADDR_W-1:0] resv_addr, word_addr;
  logic [1:0]            acc_off, acc_size;
  logic                  acc_sign, acc_write, acc_llsc;
  logic [31:0]           read_data_q, load_val, store_data;
  logic [3:0]            store_be;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;

  assign word_addr = MEM_Address[BUS_ADDR_W+1:2];
  assign is_access = MEM_MemRead | MEM_MemWrite;

  // A failed SC is decided only before issue; once an SC has completed the
  // reservation is gone, and the held result must not be overridden.
  assign sc_fail  = (state == IDLE) & MEM_MemWrite & MEM_LLSC &
                    ~(resv_valid & (resv_addr == word_addr));
  assign req      = is_access & ~addr_error & ~sc_fail;
  assign complete = (state == ACCESS) & bus.DataMem_Ready;

  // Stall never looks at MEM_PipeStall, so no loop through the hazard unit.
  assign MEM_Stall_Controller = req & (state != DONE);
  assign MEM_AddrError        = addr_error;
  assign MEM_ReadData         = sc_fail ? 32'h0 : read_data_q;
  assign debug_state          = state;

  // Alignment check: half needs A[0]=0, word (and reserved size) needs A[1:0]=0.
  always_comb begin
    addr_error = 1'b0;
    if (is_access) begin
      case (MEM_Size)
        2'b00:   addr_error = 1'b0;
        2'b01:   addr_error = MEM_Address[0];
        default: addr_error = |MEM_Address[1:0];
      endcase
    end
  end

  // Big-endian store lanes: byte 0 of a word lives in bits 31:24.
  always_comb begin
    store_be   = 4'b1111;
    store_data = MEM_WriteData;
    case (MEM_Size)
      2'b00: begin
        store_be   = 4'b1000 >> MEM_Address[1:0];
        store_data = {4{MEM_WriteData[7:0]}};
      end
      2'b01: begin
        store_be   = MEM_Address[1] ? 4'b0011 : 4'b1100;
        store_data = {2{MEM_WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension, using the offset/size latched at issue.
  always_comb begin
    load_byte = 8'h0;
    case (acc_off)
      2'd0: load_byte = bus.DataMem_In[31:24];
      2'd1: load_byte = bus.DataMem_In[23:16];
      2'd2: load_byte = bus.DataMem_In[15:8];
      2'd3: load_byte = bus.DataMem_In[7:0];
      default: ;
    endcase
    load_half = acc_off[1] ? bus.DataMem_In[15:0] : bus.DataMem_In[31:16];
    case (acc_size)
      2'b00:   load_val = {{24{acc_sign & load_byte[7]}}, load_byte};
      2'b01:   load_val = {{16{acc_sign & load_half[15]}}, load_half};
      default: load_val = bus.DataMem_In;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: one bus access per instruction, retire when MEM advances.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  if (bus.DataMem_Ready) state_next = DONE;
      DONE:    if (!MEM_PipeStall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus strobes launched from IDLE, held through ACCESS, dropped on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.DataMem_Read    <= 1'b0;
      bus.DataMem_Write   <= 4'b0000;
      bus.DataMem_Address <= '0;
      bus.DataMem_Out     <= 32'h0;
      acc_off             <= 2'b00;
      acc_size            <= 2'b00;
      acc_sign            <= 1'b0;
      acc_write           <= 1'b0;
      acc_llsc            <= 1'b0;
      read_data_q         <= 32'h0;
    end else if ((state == IDLE) && req) begin
      bus.DataMem_Read    <= ~MEM_MemWrite;
      bus.DataMem_Write   <= MEM_MemWrite ? store_be : 4'b0000;
      bus.DataMem_Address <= word_addr;
      bus.DataMem_Out     <= store_data;
      acc_off             <= MEM_Address[1:0];
      acc_size            <= MEM_Size;
      acc_sign            <= MEM_SignExtend;
      acc_write           <= MEM_MemWrite;
      acc_llsc            <= MEM_LLSC;
    end else if (complete) begin
      bus.DataMem_Read    <= 1'b0;
      bus.DataMem_Write   <= 4'b0000;
      read_data_q         <= acc_write ? {31'h0, acc_llsc} : load_val;
    end
  end

  assign resv_clear = LLSC_Clear | sc_fail |
                      (complete & acc_write &
                       (acc_llsc | (resv_valid & (resv_addr == bus.DataMem_Address))));
  assign resv_set   = complete & ~acc_write & acc_llsc;

  // LL/SC reservation; a clear beats a set arriving in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (resv_clear) begin
      resv_valid <= 1'b0;
    end else if (resv_set) begin
      resv_valid <= 1'b1;
      resv_addr  <= bus.DataMem_Address;
    end
  end
endmodule
